// File: rtl/reg_acc_ctrl.sv
// Register access controller: serialises SPI write/read requests onto a single-port
// register file, re-checking the write CRC and the write lock before any write lands.
module reg_acc_ctrl #(
  parameter int                REG_AW    = 7,
  parameter int                REG_DW    = 8,
  parameter int                REG_CRC_W = 8,
  parameter int                RD_LAT    = 1,
  parameter logic [REG_AW-1:0] PROT_BASE = 'h40
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_spi_rac_wr_req,
  input  logic                 i_spi_rac_rd_req,
  input  logic [REG_AW-1:0]    i_spi_rac_addr,
  input  logic [REG_DW-1:0]    i_spi_rac_wdata,
  input  logic [REG_CRC_W-1:0] i_spi_rac_wcrc,
  input  logic                 i_wr_lock,
  input  logic [REG_DW-1:0]    i_reg_rdata,
  output logic                 o_reg_wen,
  output logic                 o_reg_ren,
  output logic [REG_AW-1:0]    o_reg_addr,
  output logic [REG_DW-1:0]    o_reg_wdata,
  output logic                 o_rac_spi_wack,
  output logic                 o_rac_spi_rack,
  output logic [REG_AW-1:0]    o_rac_spi_addr,
  output logic [REG_DW-1:0]    o_rac_spi_data,
  output logic                 o_wcrc_err,
  output logic                 o_wr_blk_err
);

  localparam int                   CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [REG_CRC_W-1:0] CRC_POLY = 'h07;

  typedef enum logic [2:0] {IDLE, WCHK, WR, RD, RWAIT, ACK} state_t;

  // CRC-8 (poly 0x07, init 0, MSB first) over {1'b1, addr, wdata}, unrolled into one cycle.
  function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [REG_AW+REG_DW:0] din);
    logic [REG_CRC_W-1:0] crc;
    logic                 fb;
    crc = '0;
    for (int i = REG_AW + REG_DW; i >= 0; i--) begin
      fb  = crc[REG_CRC_W-1] ^ din[i];
      crc = {crc[REG_CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [REG_AW-1:0]    cap_addr, cap_addr_n;
  logic [REG_DW-1:0]    cap_wdata, cap_wdata_n;
  logic [REG_CRC_W-1:0] cap_wcrc, cap_wcrc_n;

  logic                 reg_wen_n, reg_ren_n, wack_n, rack_n, wcrc_err_n, wr_blk_err_n;
  logic [REG_AW-1:0]    reg_addr_n, ack_addr_n;
  logic [REG_DW-1:0]    reg_wdata_n, ack_data_n;

  logic                 crc_bad, lock_hit;

  assign crc_bad  = crc16to8_parallel({1'b1, cap_addr, cap_wdata}) != cap_wcrc;
  assign lock_hit = i_wr_lock && (cap_addr >= PROT_BASE);

  // Every output is registered from the value it must carry in the state being entered,
  // so strobes and acks coincide with the FSM state that owns them.
  always_comb begin
    // NOTE: every signal gets a default before the case; a missing branch would otherwise infer a latch.
    state_n      = state;
    cnt_n        = cnt;
    cap_addr_n   = cap_addr;
    cap_wdata_n  = cap_wdata;
    cap_wcrc_n   = cap_wcrc;
    reg_wen_n    = 1'b0;
    reg_ren_n    = 1'b0;
    wack_n       = 1'b0;
    rack_n       = 1'b0;
    wcrc_err_n   = 1'b0;
    wr_blk_err_n = 1'b0;
    reg_addr_n   = o_reg_addr;
    reg_wdata_n  = o_reg_wdata;
    ack_addr_n   = o_rac_spi_addr;
    ack_data_n   = o_rac_spi_data;

    unique case (state)
      IDLE: begin
        if (i_spi_rac_wr_req) begin
          cap_addr_n  = i_spi_rac_addr;
          cap_wdata_n = i_spi_rac_wdata;
          cap_wcrc_n  = i_spi_rac_wcrc;
          state_n     = WCHK;
        end else if (i_spi_rac_rd_req) begin
          cap_addr_n = i_spi_rac_addr;
          reg_ren_n  = 1'b1;
          reg_addr_n = i_spi_rac_addr;
          cnt_n      = CNT_W'(RD_LAT - 1);
          state_n    = RD;
        end
      end
      WCHK: begin
        // A rejected write still passes through WR (without the strobe) so wack timing is uniform.
        state_n      = WR;
        wcrc_err_n   = crc_bad;
        wr_blk_err_n = !crc_bad && lock_hit;
        if (!crc_bad && !lock_hit) begin
          reg_wen_n   = 1'b1;
          reg_addr_n  = cap_addr;
          reg_wdata_n = cap_wdata;
        end
      end
      WR: begin
        wack_n     = 1'b1;
        ack_addr_n = cap_addr;
        ack_data_n = cap_wdata;
        state_n    = ACK;
      end
      RD: state_n = RWAIT;
      RWAIT: begin
        if (cnt == '0) begin
          rack_n     = 1'b1;
          ack_addr_n = cap_addr;
          ack_data_n = i_reg_rdata;
          state_n    = ACK;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      cap_wcrc       <= '0;
      o_reg_wen      <= 1'b0;
      o_reg_ren      <= 1'b0;
      o_reg_addr     <= '0;
      o_reg_wdata    <= '0;
      o_rac_spi_wack <= 1'b0;
      o_rac_spi_rack <= 1'b0;
      o_rac_spi_addr <= '0;
      o_rac_spi_data <= '0;
      o_wcrc_err     <= 1'b0;
      o_wr_blk_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state          <= state_n;
      cnt            <= cnt_n;
      cap_addr       <= cap_addr_n;
      cap_wdata      <= cap_wdata_n;
      cap_wcrc       <= cap_wcrc_n;
      o_reg_wen      <= reg_wen_n;
      o_reg_ren      <= reg_ren_n;
      o_reg_addr     <= reg_addr_n;
      o_reg_wdata    <= reg_wdata_n;
      o_rac_spi_wack <= wack_n;
      o_rac_spi_rack <= rack_n;
      o_rac_spi_addr <= ack_addr_n;
      o_rac_spi_data <= ack_data_n;
      o_wcrc_err     <= wcrc_err_n;
      o_wr_blk_err   <= wr_blk_err_n;
    end
  end

endmodule
